// File: rtl/analyzer_pkg.sv
// rtl/analyzer_pkg.sv - shared types and constants for the logic analyzer capture path
package analyzer_pkg;

   // SUMP counts are expressed in units of four samples
   localparam int SUMP_COUNT_UNIT = 4;

   // Wide enough that (0xFFFF + 1) * 4 does not wrap
   localparam int CNT_W = 19;

   typedef enum logic [3:0] {
      IDLE,
      ARMED,
      DELAY,
      READ_ADDR,
      READ_WAIT,
      SEND,
      TX_HOLD,
      TX_WAIT,
      DONE
   } capture_state_t;

   // Converts a SUMP count field into a sample count: (count + 1) * 4
   function automatic logic [CNT_W-1:0] sump_target(input logic [15:0] count);
      logic [CNT_W-1:0] n;
      n = CNT_W'(count) + CNT_W'(1);
      return n * CNT_W'(SUMP_COUNT_UNIT);
   endfunction

endpackage

// File: rtl/sample_serializer.sv
// rtl/sample_serializer.sv - splits one sample into bytes and handshakes each with the UART
module sample_serializer #(
   parameter int SAMPLE_WIDTH = 8
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    abort_i,
   input  logic                    load_i,
   input  logic [SAMPLE_WIDTH-1:0] load_data_i,
   input  logic                    send_en_i,
   input  logic                    wait_en_i,
   input  logic                    tx_busy_i,
   output logic [7:0]              tx_data_o,
   output logic                    tx_start_o,
   output logic                    byte_start_o,
   output logic                    byte_done_o,
   output logic                    sample_done_o
);

   localparam int NBYTES = SAMPLE_WIDTH / 8;
   localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

   logic [SAMPLE_WIDTH-1:0] shift_q;
   logic [1:0]              idx_q;
   logic [7:0]              tx_data_q;
   logic                    tx_start_q;

   // A byte launches only once the UART is idle; it completes when busy drops again
   assign byte_start_o  = send_en_i && !tx_busy_i;
   assign byte_done_o   = wait_en_i && !tx_busy_i;
   assign sample_done_o = byte_done_o && (idx_q == LAST_IDX);

   assign tx_data_o  = tx_data_q;
   assign tx_start_o = tx_start_q;

   // Holds the sample (low byte always at bits 7:0), the byte index and the UART request
   always_ff @(posedge clock_i) begin
      if (reset_i || abort_i) begin
         shift_q    <= '0;
         idx_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         tx_start_q <= byte_start_o;
         if (byte_start_o) begin
            tx_data_q <= shift_q[7:0];
         end
         if (load_i) begin
            shift_q <= load_data_i;
            idx_q   <= '0;
         end else if (byte_done_o && !sample_done_o) begin
            shift_q <= shift_q >> 8;
            idx_q   <= idx_q + 2'd1;
         end
      end
   end

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - arms, fills the circular sample RAM, and streams samples newest-first
module capture_sequencer
   import analyzer_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 8,
   parameter int ADDR_WIDTH   = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    arm,
   input  logic                    abort,
   input  logic [15:0]             read_count,
   input  logic [15:0]             delay_count,
   input  logic                    sample_valid,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic                    run,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_waddr,
   output logic [SAMPLE_WIDTH-1:0] mem_wdata,
   output logic [ADDR_WIDTH-1:0]   mem_raddr,
   input  logic [SAMPLE_WIDTH-1:0] mem_rdata,
   output logic [7:0]              tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic                    busy,
   output logic                    capture_done
);

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(1) << ADDR_WIDTH;

   capture_state_t          state_q;
   logic [ADDR_WIDTH-1:0]   wptr_q;
   logic [ADDR_WIDTH-1:0]   rptr_q;
   logic [CNT_W-1:0]        dcnt_q;
   logic [CNT_W-1:0]        dcnt_d;
   logic [CNT_W-1:0]        remaining_q;
   logic [CNT_W-1:0]        read_tgt_q;
   logic [CNT_W-1:0]        delay_tgt_q;
   logic [CNT_W-1:0]        read_req;
   logic                    done_q;
   logic                    write_en;
   logic                    byte_start;
   logic                    byte_done;
   logic                    sample_done;

   // The write port is combinational so the final post-trigger sample is in RAM
   // before the first read address is presented
   assign write_en  = sample_valid && !abort && !reset &&
                      (state_q == ARMED || state_q == DELAY);
   assign mem_we    = write_en;
   assign mem_waddr = wptr_q;
   assign mem_wdata = write_en ? sample_in : '0;
   assign mem_raddr = rptr_q;

   assign busy         = (state_q != IDLE);
   assign capture_done = done_q;

   assign read_req = sump_target(read_count);
   assign dcnt_d   = dcnt_q + CNT_W'(1);

   // Main acquisition FSM; abort behaves exactly like reset
   always_ff @(posedge clock) begin
      if (reset || abort) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         rptr_q      <= '0;
         dcnt_q      <= '0;
         remaining_q <= '0;
         read_tgt_q  <= '0;
         delay_tgt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (write_en) begin
            wptr_q <= wptr_q + ADDR_WIDTH'(1);
         end
         case (state_q)
            IDLE: begin
               if (arm) begin
                  state_q     <= ARMED;
                  read_tgt_q  <= (read_req > DEPTH_CNT) ? DEPTH_CNT : read_req;
                  delay_tgt_q <= sump_target(delay_count);
                  wptr_q      <= '0;
               end
            end
            ARMED: begin
               if (run) begin
                  state_q <= DELAY;
                  dcnt_q  <= '0;
               end
            end
            DELAY: begin
               if (write_en) begin
                  dcnt_q <= dcnt_d;
                  if (dcnt_d == delay_tgt_q) begin
                     state_q     <= READ_ADDR;
                     rptr_q      <= wptr_q;
                     remaining_q <= read_tgt_q;
                  end
               end
            end
            READ_ADDR: state_q <= READ_WAIT;
            READ_WAIT: state_q <= SEND;
            SEND: begin
               if (byte_start) begin
                  state_q <= TX_HOLD;
               end
            end
            TX_HOLD: state_q <= TX_WAIT;
            TX_WAIT: begin
               if (sample_done) begin
                  remaining_q <= remaining_q - CNT_W'(1);
                  rptr_q      <= rptr_q - ADDR_WIDTH'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= READ_ADDR;
                  end
               end else if (byte_done) begin
                  state_q <= SEND;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   sample_serializer #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH)
   ) u_serializer (
      .clock_i       (clock),
      .reset_i       (reset),
      .abort_i       (abort),
      .load_i        (state_q == READ_WAIT),
      .load_data_i   (mem_rdata),
      .send_en_i     (state_q == SEND),
      .wait_en_i     (state_q == TX_WAIT),
      .tx_busy_i     (tx_busy),
      .tx_data_o     (tx_data),
      .tx_start_o    (tx_start),
      .byte_start_o  (byte_start),
      .byte_done_o   (byte_done),
      .sample_done_o (sample_done)
   );

endmodule
